// File: rtl/rgba_gray_feeder_if.sv
// Valid/ready stream bundle. Carries RGBA cache lines into the feeder and
// packed luma beats out of it. WIDTH sets the data bus width.
interface rgba_gray_feeder_if #(
    parameter int WIDTH = 512
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    // Producer side: drives data/valid, observes ready.
    modport master (
        output valid,
        output data,
        input  ready
    );

    // Consumer side: observes data/valid, drives ready.
    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/rgba_gray_feeder.sv
// RGBA-to-luma front end for the Sobel pipeline. Each accepted 512-bit line
// holds 16 BGRA pixels; each is reduced to Y = (77R + 150G + 29B + 128) >> 8
// through a two-stage pipeline, and the 16 luma bytes are packed into one
// 128-bit beat that is queued in a small output FIFO. Acceptance is
// credit-limited so the FIFO can never overflow, and a small FSM counts lines
// per frame and pulses done when the last beat leaves.
module rgba_gray_feeder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start,
    input  logic [31:0]         num_lines,
    rgba_gray_feeder_if.slave   in_if,
    rgba_gray_feeder_if.master  out_if,
    output logic                busy,
    output logic                done
);
    localparam int PIXELS = 16;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [31:0] num_lines_reg;
    logic [31:0] acc_cnt_reg;
    logic [31:0] emit_cnt_reg;

    logic         s1_valid_reg;
    logic         s2_valid_reg;
    logic [127:0] s2_data_reg;
    logic [127:0] luma_line;

    logic [127:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] fifo_count_reg;

    logic [1:0]       inflight;
    logic [CNT_W:0]   occupancy;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;

    // Credits: FIFO entries plus lines still travelling through the pipeline.
    assign inflight  = {1'b0, s1_valid_reg} + {1'b0, s2_valid_reg};
    assign occupancy = {1'b0, fifo_count_reg} + {{(CNT_W - 1){1'b0}}, inflight};

    assign in_if.ready = (state_reg == ST_RUN)
                       && (acc_cnt_reg < num_lines_reg)
                       && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign accept      = in_if.valid && in_if.ready;

    assign fifo_nonempty = (fifo_count_reg != '0);
    assign out_if.valid  = fifo_nonempty;
    assign out_if.data   = fifo_nonempty ? fifo_mem[rd_ptr_reg] : '0;
    assign pop           = fifo_nonempty && out_if.ready;
    assign push          = s2_valid_reg;

    assign busy = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done = (state_reg == ST_DONE);

    // Per-pixel datapath: stage 1 holds the three weighted channels, the
    // rounded sum is formed from those registers and packed into stage 2.
    generate
        for (genvar gi = 0; gi < PIXELS; gi++) begin : g_pixel
            logic [15:0] r_prod_reg;
            logic [15:0] g_prod_reg;
            logic [15:0] b_prod_reg;
            logic [15:0] sum;
            logic        unused_alpha;

            // Alpha byte carries no luma information.
            assign unused_alpha = ^in_if.data[32*gi+24 +: 8];

            // Stage 1: capture products when a line is accepted.
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    r_prod_reg <= '0;
                    g_prod_reg <= '0;
                    b_prod_reg <= '0;
                end else if (accept) begin
                    r_prod_reg <= 16'd77  * {8'd0, in_if.data[32*gi+16 +: 8]};
                    g_prod_reg <= 16'd150 * {8'd0, in_if.data[32*gi+8  +: 8]};
                    b_prod_reg <= 16'd29  * {8'd0, in_if.data[32*gi    +: 8]};
                end
            end

            // Worst case 65408, so 16 bits never wrap.
            assign sum = r_prod_reg + g_prod_reg + b_prod_reg + 16'd128;
            assign luma_line[8*gi +: 8] = sum[15:8];
        end
    endgenerate

    // Pipeline valid bits and the stage-2 packed beat.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
        end else begin
            s1_valid_reg <= accept;
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg <= luma_line;
            end
        end
    end

    // FIFO storage: contents need no reset, the count decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= s2_data_reg;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count as is.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // Credit accounting must make a push into a full, non-popping FIFO impossible.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            assert (!(push && !pop && (fifo_count_reg == CNT_W'(FIFO_DEPTH))));
        end
    end

    // Frame bookkeeping: length latched on start, accept/emit line counters.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            num_lines_reg <= '0;
            acc_cnt_reg   <= '0;
            emit_cnt_reg  <= '0;
        end else if ((state_reg == ST_IDLE) && start) begin
            num_lines_reg <= num_lines;
            acc_cnt_reg   <= '0;
            emit_cnt_reg  <= '0;
        end else begin
            if (accept) begin
                acc_cnt_reg <= acc_cnt_reg + 32'd1;
            end
            if (pop) begin
                emit_cnt_reg <= emit_cnt_reg + 32'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; DRAIN exits on the pop of the last line so done
    // appears on the very next cycle.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_lines == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (acc_cnt_reg == num_lines_reg) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && ((emit_cnt_reg + 32'd1) == num_lines_reg)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_rgba_gray_feeder.sv
// Directed bench for rgba_gray_feeder: reset values, a hand-computed
// single-line frame, zero-length frame, streaming, backpressure, random
// stalls and an asynchronous reset in the middle of a frame.
module tb_rgba_gray_feeder;
    localparam int DEPTH = 4;
    localparam int LIMIT = 4000;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic [31:0] num_lines;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    rgba_gray_feeder_if #(.WIDTH(512)) in_if ();
    rgba_gray_feeder_if #(.WIDTH(128)) out_if ();

    always #5 clk = ~clk;

    rgba_gray_feeder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .num_lines (num_lines),
        .in_if     (in_if),
        .out_if    (out_if),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference luma for a whole line.
    function automatic logic [127:0] luma_ref(input logic [511:0] l);
        logic [127:0] res;
        int r, g, b, y;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            r = int'(l[32*i+16 +: 8]);
            g = int'(l[32*i+8  +: 8]);
            b = int'(l[32*i    +: 8]);
            y = (77 * r + 150 * g + 29 * b + 128) >> 8;
            res[8*i +: 8] = y[7:0];
        end
        return res;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) begin
            l[32*i +: 32] = $urandom();
        end
        return l;
    endfunction

    // Runs one frame with a scoreboard. vpct/rpct are valid_in/ready_out
    // percentages, hold forces ready_out low for the first cycles, poke fires
    // a stray start mid-frame, stream checks back-to-back acceptance.
    task automatic run_frame(input string tag, input int n, input int vpct, input int rpct,
                             input int hold, input bit poke, input bit stream);
        logic [127:0] exp_q[$];
        logic [511:0] line;
        logic [127:0] held_data;
        logic         held_valid;
        int acc, emit, dones, cyc, first_acc, last_acc, max_out, stab_bad;
        acc = 0; emit = 0; dones = 0; cyc = 0; first_acc = -1; last_acc = -1;
        max_out = 0; stab_bad = 0; held_valid = 1'b0; held_data = '0;
        line = rand_line();
        @(negedge clk);
        start = 1'b1;
        num_lines = n;
        @(negedge clk);
        start = 1'b0;
        while ((emit < n || dones == 0) && cyc < LIMIT) begin
            in_if.data  = line;
            in_if.valid = ($urandom_range(99) < vpct);
            out_if.ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rpct);
            start = poke && (cyc == 10);
            if (poke && cyc == 10) num_lines = 3;
            #1;
            if (acc - emit > max_out) max_out = acc - emit;
            if (hold > 0 && cyc == hold) begin
                chk({tag, "_bp_accepts"}, acc, DEPTH);
                chk({tag, "_bp_ready_in"}, in_if.ready, 1'b0);
            end
            if (held_valid && !(out_if.valid && out_if.data == held_data)) stab_bad++;
            held_valid = out_if.valid && !out_if.ready;
            held_data  = out_if.data;
            if (done) dones++;
            if (in_if.valid && in_if.ready) begin
                exp_q.push_back(luma_ref(line));
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                acc++;
                line = rand_line();
            end
            if (out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) chk({tag, "_spurious_out"}, out_if.valid, 1'b0);
                else chk({tag, "_data"}, out_if.data, exp_q.pop_front());
                emit++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (done) dones++;
            if (in_if.valid && in_if.ready) acc++;
            @(negedge clk);
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        chk({tag, "_no_timeout"}, (cyc < LIMIT), 1'b1);
        chk({tag, "_accepts"}, acc, n);
        chk({tag, "_emits"}, emit, n);
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_left_over"}, exp_q.size(), 0);
        chk({tag, "_credit_bound"}, (max_out <= DEPTH), 1'b1);
        chk({tag, "_stall_stable"}, stab_bad, 0);
        if (stream) chk({tag, "_one_per_cycle"}, last_acc - first_acc, n - 1);
    endtask

    initial begin
        logic [511:0] pix_line;
        logic [127:0] pix_exp;
        rst_b = 1'b1;
        start = 1'b0;
        num_lines = '0;
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b0;
        #1 rst_b = 1'b0;
        #1;
        chk("rst_ready_in", in_if.ready, 1'b0);
        chk("rst_valid_out", out_if.valid, 1'b0);
        chk("rst_data_out", out_if.data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        // Single line: pure red, green, blue, white, then alpha-only pixels.
        pix_line = {{12{32'hFF000000}}, 32'h00FFFFFF, 32'h000000FF, 32'h0000FF00, 32'h00FF0000};
        pix_exp  = {96'h0, 32'hFF1D954D};
        @(negedge clk);
        start = 1'b1;
        num_lines = 1;
        #1 chk("one_busy_before", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        in_if.valid = 1'b1;
        in_if.data = pix_line;
        #1;
        chk("one_ready_in", in_if.ready, 1'b1);
        chk("one_busy", busy, 1'b1);
        @(negedge clk);
        in_if.data = rand_line();
        #1;
        chk("one_extra_refused", in_if.ready, 1'b0);
        chk("one_valid_out_c1", out_if.valid, 1'b0);
        @(negedge clk);
        #1 chk("one_valid_out_c2", out_if.valid, 1'b0);
        @(negedge clk);
        #1;
        chk("one_valid_out_c3", out_if.valid, 1'b1);
        chk("one_data", out_if.data, pix_exp);
        chk("one_done_early", done, 1'b0);
        out_if.ready = 1'b1;
        @(negedge clk);
        in_if.valid = 1'b0;
        #1;
        chk("one_done", done, 1'b1);
        chk("one_busy_fall", busy, 1'b0);
        chk("one_no_extra_out", out_if.valid, 1'b0);
        out_if.ready = 1'b0;
        @(negedge clk);
        #1 chk("one_done_pulse", done, 1'b0);

        // Zero-length frame.
        @(negedge clk);
        start = 1'b1;
        num_lines = 0;
        in_if.valid = 1'b1;
        #1 chk("zero_ready_in_idle", in_if.ready, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_ready_in", in_if.ready, 1'b0);
        @(negedge clk);
        #1;
        chk("zero_done_pulse", done, 1'b0);
        chk("zero_busy_after", busy, 1'b0);
        in_if.valid = 1'b0;

        run_frame("stream", 64, 100, 100, 0, 1'b1, 1'b1);
        run_frame("bp", 12, 100, 100, 20, 1'b0, 1'b0);
        run_frame("rand", 200, 70, 50, 0, 1'b0, 1'b0);

        // Asynchronous reset with three lines sitting in the FIFO.
        @(negedge clk);
        start = 1'b1;
        num_lines = 10;
        @(negedge clk);
        start = 1'b0;
        in_if.valid = 1'b1;
        in_if.data = rand_line();
        out_if.ready = 1'b0;
        repeat (5) @(negedge clk);
        #1 chk("arst_pre_valid_out", out_if.valid, 1'b1);
        #1 rst_b = 1'b0;
        #1;
        chk("arst_ready_in", in_if.ready, 1'b0);
        chk("arst_valid_out", out_if.valid, 1'b0);
        chk("arst_data_out", out_if.data, '0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk);
        in_if.valid = 1'b0;
        rst_b = 1'b1;
        run_frame("post_rst", 5, 100, 100, 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rgba_gray_feeder.md
# rgba_gray_feeder

Front end of the Sobel edge-detection pipeline. Accepts 512-bit cache lines of 16 RGBA pixels from the read path and converts each pixel to 8-bit luma. Packs the 16 luma bytes into one 128-bit beat for the grayscale edge-detection unit. This is the counterpart of the unit's 128-bit-gray-in / 512-bit-RGBA-out format. Adds valid/ready flow control, a small output FIFO and per-frame line accounting.

## Interface
- FIFO_DEPTH, 4: output FIFO entries (power of two, ≥ 4).
- clk  in  1  clock; all logic on rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE.
- num_lines  in  32  number of 512-bit lines in the frame; sampled on start.
- valid_in  in  1  data_in valid.
- data_in  in  512  pixel i at [32*i +: 32]; byte0 = B, byte1 = G, byte2 = R, byte3 ignored.
- ready_in  out  1  block accepts data_in this cycle.
- valid_out  out  1  data_out valid (FIFO not empty).
- data_out  out  128  luma of pixel i at [8*i +: 8].
- ready_out  in  1  downstream takes data_out.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the last line of the frame is emitted.

## Operation
- **States**
  - IDLE: ready_in = 0.
    - start with num_lines ≠ 0 → RUN. Latch num_lines; clear acc_cnt and emit_cnt.
    - start with num_lines = 0 → DONE.
  - RUN: accept lines. When acc_cnt reaches num_lines → DRAIN.
  - DRAIN: ready_in = 0. When emit_cnt reaches num_lines → DONE.
  - DONE: done = 1 for one cycle, then → IDLE unconditionally.
- start outside IDLE is ignored.
- **Accept/emit**
  - Accept when valid_in & ready_in. Increment acc_cnt.
  - ready_in = (state == RUN) & (acc_cnt < num_lines) & (fifo_count + inflight < FIFO_DEPTH).
    - inflight = number of valid pipeline stages (0–2).
  - Emit when valid_out & ready_out. Pop FIFO and increment emit_cnt.
- **Luma, per pixel, 16 in parallel:** Y = (77·R + 150·G + 29·B + 128) >> 8.
  - Products are 16 bits unsigned; sum is 16 bits unsigned. Maximum sum is 65408, so no overflow.
  - Result is bits [15:8]; range 0–255, no clamping needed.
- **Pipeline**
  - Stage 1 registers the three products per pixel plus a valid bit.
  - Stage 2 registers the sum, shift and 128-bit pack plus a valid bit.
  - The stage-2 output is written into the FIFO.
- **FIFO**
  - Circular buffer with wrapping read/write pointers and an explicit count.
  - Simultaneous push and pop leave the count unchanged. A pop is allowed even when full.
  - Credit accounting guarantees the FIFO never overflows; overflow is an assertion failure.
- data_out = FIFO head when valid_out = 1, else 0.

## Timing
- **Reset values:** ready_in 0, valid_out 0, data_out 0, busy 0, done 0; state IDLE; counters, pointers and stage valids 0.
- Reset is asynchronous and abandons any frame in progress. FIFO contents are discarded.
- First accept is possible on the cycle after start (state = RUN).
- **Latency:** a line accepted at edge E is in stage 1 after E, in stage 2 after E+1, and in the FIFO after E+2. valid_out rises after E+2 when the FIFO was empty.
- **Throughput:** one line per cycle with ready_out held high.
- Under backpressure, ready_in drops in the same cycle fifo_count + inflight reaches FIFO_DEPTH. It recovers the cycle after a pop frees a credit.
- data_out and valid_out stay stable while valid_out & !ready_out.
- done pulses the cycle after the edge that popped the last line. busy falls in the same cycle.
- With num_lines = 0, done pulses the cycle after start. busy is never asserted and nothing is accepted.
- Lines presented after acc_cnt = num_lines see ready_in = 0 and are not consumed.

## Test plan
- **Single pixel:** num_lines = 1; pixels 0..3 = 0x00FF0000, 0x0000FF00, 0x000000FF, 0x00FFFFFF; rest 0xFF000000. Expected data_out bytes 0..3 = 0x4D, 0x95, 0x1D, 0xFF; rest 0x00. valid_out 3 cycles after accept; done 1 cycle after pop.
- **Streaming:** num_lines = 64 random lines, ready_out = 1, valid_in = 1. Expected one accept per cycle, 64 outputs matching the reference model in order, exactly one done pulse.
- **Backpressure:** ready_out = 0 for 20 cycles, valid_in = 1. Expected exactly FIFO_DEPTH accepts, then ready_in = 0 and data_out stable. Release: no loss or duplication, order preserved.
- **Random stall:** ready_out random at 50%, valid_in random at 70%, 200 lines. Expected scoreboard match, FIFO count ≤ FIFO_DEPTH, done once at line 200.
- **Boundaries:**
  - num_lines = 0 → done after 1 cycle, no accepts.
  - start during RUN → ignored.
  - Extra valid_in after the last accept → not consumed.
- **Async reset mid-frame:** assert rst_b low with 3 lines in the FIFO. Expected all outputs at reset values immediately. A new frame after release produces only new data.
